// File: rtl/decoder_3x8_seq.sv
// Buffered 3-to-8 decoder: FIFO of encoded codes, head is presented one-hot under valid/ready.
// Build option: define DECODER_HOLD_EN to make D keep the last popped value while the FIFO is empty.
module decoder_3x8_seq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    input  logic       V,
    output logic       in_ready,
    output logic [7:0] D,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] count
);

    localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  FULL_COUNT = 5'(DEPTH);

    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    count_q;
    logic          push;
    logic          pop;
    logic [7:0]    head_onehot;

    // Full/empty come from the occupancy counter, so no extra pointer bit is needed.
    always_comb begin
        in_ready    = !rst && (count_q != FULL_COUNT);
        out_valid   = !rst && (count_q != '0);
        push        = V && in_ready;
        pop         = out_valid && out_ready;
        head_onehot = 8'b0000_0001 << mem[rd_ptr];
        count       = count_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {x, y, z};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef DECODER_HOLD_EN
    logic [7:0] last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= '0;
        end else if (pop) begin
            last_d <= head_onehot;
        end
    end

    always_comb begin
        D = out_valid ? head_onehot : last_d;
    end
`else
    always_comb begin
        D = out_valid ? head_onehot : '0;
    end
`endif

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Self-checking bench for decoder_3x8_seq: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours DECODER_HOLD_EN like the design.
module tb_decoder_3x8_seq;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0, y = 1'b0, z = 1'b0;
    logic       V = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [7:0] D;
    logic       out_valid;
    logic [4:0] count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          checking = 1'b0;

`ifdef DECODER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    decoder_3x8_seq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .z         (z),
        .V         (V),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored codes and the last value handed to the consumer.
    logic [2:0] q[$];
    logic [7:0] last_popped = 8'h00;

    always @(posedge clk) begin
        bit do_pop, do_push;
        if (rst) begin
            q.delete();
            last_popped = 8'h00;
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = V && (q.size() != DEPTH);
            if (do_pop) begin
                last_popped = 8'(1) << q[0];
                void'(q.pop_front());
            end
            if (do_push) q.push_back({x, y, z});
        end
    end

    always @(negedge clk) begin
        logic       exp_ov;
        logic [7:0] exp_d;
        if (checking) begin
            exp_ov = !rst && (q.size() != 0);
            if (exp_ov)     exp_d = 8'(1) << q[0];
            else if (HOLD)  exp_d = last_popped;
            else            exp_d = 8'h00;
            check("model_in_ready", 32'(in_ready), 32'(!rst && (q.size() != DEPTH)));
            check("model_out_valid", 32'(out_valid), 32'(exp_ov));
            check("model_count", 32'(count), 32'(q.size()));
            check("model_D", 32'(D), 32'(exp_d));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [2:0] code);
        V = valid;
        {x, y, z} = code;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cycle();
        checking = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_count", 32'(count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_D", 32'(D), 32'h00);

        // Single code 6
        out_ready = 1'b1;
        drive(1'b1, 3'd6);
        cycle();
        drive(1'b0, 3'd0);
        check("single_D", 32'(D), 32'h40);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_count", 32'(count), 32'd1);
        cycle();
        check("single_after_out_valid", 32'(out_valid), 32'd0);
        check("single_after_count", 32'(count), 32'd0);
        check("single_after_D", 32'(D), HOLD ? 32'h40 : 32'h00);

        // Fill to full, offer a refused code, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i));
            cycle();
        end
        drive(1'b0, 3'd0);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_D", 32'(D), 32'h01);
        drive(1'b1, 3'd7);
        cycle();
        drive(1'b0, 3'd0);
        check("full_ignored_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_D", 32'(D), 32'(8'(1) << i));
            cycle();
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // Push and pop together while full: only the pop happens
        out_ready = 1'b0;
        for (int i = 3; i < 7; i++) begin
            drive(1'b1, 3'(i));
            cycle();
        end
        drive(1'b1, 3'd7);
        out_ready = 1'b1;
        cycle();
        drive(1'b0, 3'd0);
        out_ready = 1'b0;
        check("pushpop_full_count", 32'(count), 32'd3);
        check("pushpop_full_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        check("pushpop_drain0", 32'(D), 32'h10);
        cycle();
        check("pushpop_drain1", 32'(D), 32'h20);
        cycle();
        check("pushpop_drain2", 32'(D), 32'h40);
        cycle();
        check("pushpop_not_stored", 32'(out_valid), 32'd0);

        // Wrap-around with streaming consumer
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(i % 8));
            cycle();
            check("wrap_D", 32'(D), 32'(8'(1) << (i % 8)));
            check("wrap_count", 32'(count), 32'd1);
        end
        drive(1'b0, 3'd0);
        cycle();
        check("wrap_end_count", 32'(count), 32'd0);

        // Backpressure hold on code 5
        out_ready = 1'b0;
        drive(1'b1, 3'd5);
        cycle();
        drive(1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            check("hold_D", 32'(D), 32'h20);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        check("hold_released", 32'(out_valid), 32'd0);

        // Reset with three codes stored
        out_ready = 1'b0;
        drive(1'b1, 3'd1); cycle();
        drive(1'b1, 3'd2); cycle();
        drive(1'b1, 3'd4); cycle();
        drive(1'b0, 3'd0);
        check("midrst_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        cycle();
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_D", 32'(D), 32'h00);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
